pwm_bank_ctrl: RTL
==================

# pwm_bank_ctrl

Multi-channel, button-driven PWM controller: one shared prescaler and period counter drive CHANNELS independent PWM outputs. Each channel has a WIDTH-bit duty cycle adjusted by single-cycle up/down/select pulses from the board debouncers. Duty changes saturate at the limits and take effect only at a period boundary, so output waveforms never glitch. An optional ramp mode sweeps the selected channel's duty as a triangle, for LED "breathing" demos and scope checks on the JA header.

## Interface
- CHANNELS, 4: number of PWM outputs (≥1).
- WIDTH, 8: duty and period-counter width; period = 2^WIDTH ticks.
- STEP, 5: duty increment/decrement per pulse or ramp step (1 ≤ STEP ≤ 2^WIDTH−1).
- PRESCALE, 128: CLK cycles per PWM tick (≥1).

- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- up_pulse  in  1  one-cycle request: selected channel duty += STEP.
- dn_pulse  in  1  one-cycle request: selected channel duty −= STEP.
- sel_pulse  in  1  one-cycle request: advance channel select.
- ramp_en  in  1  level: selected channel auto-ramps; up/dn ignored.
- pwm_out  out  CHANNELS  registered PWM outputs, bit i = channel i.
- sel_ch  out  max(1,$clog2(CHANNELS))  currently selected channel.
- duty_sel  out  WIDTH  pending duty of the selected channel.

## Operation
- Prescaler counts 0..PRESCALE−1 and wraps. tick = (prescaler == PRESCALE−1).
- Period counter cnt (WIDTH bits) increments on tick and wraps 2^WIDTH−1 → 0. period_start = tick AND cnt == 2^WIDTH−1.
- Each channel has pending[i] and active[i] duty registers. On period_start, active[i] ← pending[i] for all i.
- pwm_out[i] ← (cnt_next < active_next[i]), registered. Duty 0 gives constant low. Duty 2^WIDTH−1 gives high for 2^WIDTH−1 of 2^WIDTH ticks.
- Manual mode (ramp_en = 0):
  - up_pulse only: pending[sel] ← min(pending + STEP, 2^WIDTH−1). Compute in WIDTH+1 bits; no wrap.
  - dn_pulse only: pending[sel] ← max(pending − STEP, 0).
  - up_pulse and dn_pulse together: no change.
- sel_pulse: sel ← sel + 1, wrapping CHANNELS−1 → 0.
  - Simultaneous sel_pulse and up/dn: the duty change applies to the old sel; sel advances in the same cycle.
- Ramp mode (ramp_en = 1): on each period_start, pending[sel] steps by STEP in direction dir, saturating as in manual mode.
  - If the step reaches 2^WIDTH−1, dir ← down. If it reaches 0, dir ← up.
  - up/dn pulses are ignored. sel_pulse is still honoured; dir is kept when sel changes.
  - ramp_en deassert freezes pending[sel] at its current value.
- Ramp update and the active load in the same cycle: active loads the pre-update pending value.
- Non-selected channels never change pending.

## Timing
- Reset (RST high at a CLK edge) sets the following on the next edge:
  - prescaler = 0, cnt = 0, all pending and active = 0, sel = 0, dir = up.
  - pwm_out = 0, sel_ch = 0, duty_sel = 0.
  - RST mid-period aborts the period immediately; the first new period begins at the cycle after RST releases.
- duty_sel reflects a pulse 1 cycle after the pulse cycle.
- sel_ch updates 1 cycle after sel_pulse. duty_sel follows the new channel in the same cycle.
- A pending change reaches pwm_out at the first period_start after it. Worst-case latency is PRESCALE·2^WIDTH + 1 CLK cycles.
- Period length is exactly PRESCALE·2^WIDTH CLK cycles. High time is active[i]·PRESCALE cycles.
- Pulses arriving on every cycle are all honoured; no pulse is dropped.

## Structure
- Shared package/header `pwm_pkg`: default parameter values and the select-width function `sel_w(CHANNELS)`.
- Top module contains the prescaler, period counter, select register, ramp direction and pending-duty update logic.
- Sub-module `pwm_channel`, generated per channel:
  - inputs: CLK, RST, period_start, pending duty, cnt.
  - holds the active duty register and compare logic.
  - output: one registered pwm_out bit.

## Test plan
All scenarios use PRESCALE=2, WIDTH=4, STEP=5, CHANNELS=4; period = 32 cycles.
- Reset, then 3× up_pulse on ch0: duty_sel 5 → 10 → 15. A 4th up holds at 15. From the next period, pwm_out[0] is high 30 of 32 cycles; other outputs stay low.
- dn_pulse at duty 3: result is 0, not wrap to 14. up_pulse and dn_pulse in the same cycle: duty unchanged.
- sel_pulse ×5: sel_ch 1, 2, 3, 0, 1. sel_pulse together with up_pulse while sel=2: ch2 += 5, sel_ch becomes 3.
- Duty set to 10 mid-period while active is 5: the current period stays high 10 cycles; the next period is high 20 cycles, with no partial pulse.
- ramp_en on ch1 from 0: per-period pending sequence 5, 10, 15, 10, 5, 0, 5. up_pulse is ignored throughout.
- RST asserted mid-period with ch0 at 15: next cycle all outputs are 0 and sel_ch = 0. After release, pwm_out stays low for 32+ cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the PWM bank controller.
package pwm_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_STEP     = 5;
    localparam int DEF_PRESCALE = 128;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: holds the active duty and compares it against the period count.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_period_start,
    input  logic [WIDTH-1:0] i_pending,
    input  logic [WIDTH-1:0] i_cnt_nxt,
    output logic             o_pwm
);

    logic [WIDTH-1:0] r_active;
    logic             r_pwm;
    logic [WIDTH-1:0] w_active_nxt;

    // Compare against next-cycle values so the registered output lines up with cnt.
    assign w_active_nxt = i_period_start ? i_pending : r_active;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            r_pwm    <= (i_cnt_nxt < w_active_nxt);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_bank_ctrl.sv
// Button-driven PWM bank: shared prescaler/period counter, per-channel pending duty,
// channel select and an optional triangle ramp on the selected channel.
module pwm_bank_ctrl
    import pwm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STEP     = DEF_STEP,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       up_pulse,
    input  logic                       dn_pulse,
    input  logic                       sel_pulse,
    input  logic                       ramp_en,
    output logic [CHANNELS-1:0]        pwm_out,
    output logic [sel_w(CHANNELS)-1:0] sel_ch,
    output logic [WIDTH-1:0]           duty_sel
);

    localparam int               SW       = sel_w(CHANNELS);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] DMAX     = '1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]    SEL_LAST = SW'(CHANNELS - 1);

    // Add/subtract one step with one spare bit so the limits clamp instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] s;
        s = {1'b0, d} + (WIDTH + 1)'(STEP);
        return (s > {1'b0, DMAX}) ? DMAX : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] d);
        return ({1'b0, d} < (WIDTH + 1)'(STEP)) ? '0 : d - WIDTH'(STEP);
    endfunction

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_cnt;
    logic [SW-1:0]    r_sel;
    dir_e             r_dir;
    logic [WIDTH-1:0] r_pending [CHANNELS];

    logic             w_tick;
    logic             w_period_start;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_cur;
    logic             w_upd_en;
    logic [WIDTH-1:0] w_upd_val;
    dir_e             w_dir_nxt;

    assign w_tick         = (r_pre == PRE_LAST);
    assign w_period_start = w_tick && (r_cnt == DMAX);
    assign w_cnt_nxt      = w_tick ? r_cnt + 1'b1 : r_cnt;
    assign w_cur          = r_pending[r_sel];

    always_comb begin
        w_upd_en  = 1'b0;
        w_upd_val = w_cur;
        w_dir_nxt = r_dir;
        if (ramp_en) begin
            if (w_period_start) begin
                w_upd_en  = 1'b1;
                w_upd_val = (r_dir == DIR_UP) ? sat_inc(w_cur) : sat_dec(w_cur);
                if (w_upd_val == DMAX) begin
                    w_dir_nxt = DIR_DN;
                end else if (w_upd_val == '0) begin
                    w_dir_nxt = DIR_UP;
                end
            end
        end else if (up_pulse != dn_pulse) begin
            w_upd_en  = 1'b1;
            w_upd_val = up_pulse ? sat_inc(w_cur) : sat_dec(w_cur);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_sel <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            if (sel_pulse) begin
                r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
            end
        end
    end

    // The update targets the select value of this cycle, even if sel advances too.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (RST) begin
                r_pending[i] <= '0;
            end else if (w_upd_en && (r_sel == SW'(i))) begin
                r_pending[i] <= w_upd_val;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .CLK           (CLK),
            .RST           (RST),
            .i_period_start(w_period_start),
            .i_pending     (r_pending[g]),
            .i_cnt_nxt     (w_cnt_nxt),
            .o_pwm         (pwm_out[g])
        );
    end

    assign sel_ch   = r_sel;
    assign duty_sel = w_cur;

endmodule
